mdr: RTL and testbench

//   16-bit Memory Data Register between the CPU internal data bus and the memory data port.

---
 rtl/mdr.sv | 49 ++++
 tb/tb_mdr.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mdr.sv
// Memory Data Register: one WIDTH-bit word between the CPU data bus and the memory data port.
// Loads from either tri-state bus on the rising edge and drives the stored word back onto either bus.
module mdr #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             R_W,
    input  logic             in_bus_en,
    input  logic             in_mem_en,
    input  logic             out_bus_en,
    input  logic             out_mem_en,
    inout  wire  [WIDTH-1:0] data_bus,
    inout  wire  [WIDTH-1:0] data_mem
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             mem_drive;
    logic             sel_mem;
    logic             sel_bus;

    always_comb begin
        mem_drive = out_mem_en & ~R_W;
        // Exactly one source is selected; R_W breaks the tie when both enables are set.
        sel_mem   = in_mem_en & (~in_bus_en | R_W);
        sel_bus   = in_bus_en & (~in_mem_en | ~R_W);
        data_d    = data_q;
        // A selected source that the MDR is itself driving is ignored and the word holds.
        if (sel_mem && !mem_drive) begin
            data_d = data_mem;
        end else if (sel_bus && !out_bus_en) begin
            data_d = data_bus;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    // Memory is only driven on writes so it never fights the memory's read data.
    assign data_bus = out_bus_en ? data_q : {WIDTH{1'bz}};
    assign data_mem = mem_drive  ? data_q : {WIDTH{1'bz}};

endmodule

// File: tb/tb_mdr.sv
// Bench for mdr: a table of load vectors observed through data_bus, plus hand sequences
// for reset, drive gating, asynchronous reset and the self-load guard.
module tb_mdr;

    localparam int W = 16;

    logic         clk;
    logic         reset;
    logic         r_w;
    logic         in_bus_en;
    logic         in_mem_en;
    logic         out_bus_en;
    logic         out_mem_en;
    logic         bus_drv_en;
    logic         mem_drv_en;
    logic [W-1:0] bus_drv;
    logic [W-1:0] mem_drv;
    wire  [W-1:0] data_bus;
    wire  [W-1:0] data_mem;

    int n_vec;
    int n_fail;

    assign data_bus = bus_drv_en ? bus_drv : {W{1'bz}};
    assign data_mem = mem_drv_en ? mem_drv : {W{1'bz}};

    mdr #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .R_W        (r_w),
        .in_bus_en  (in_bus_en),
        .in_mem_en  (in_mem_en),
        .out_bus_en (out_bus_en),
        .out_mem_en (out_mem_en),
        .data_bus   (data_bus),
        .data_mem   (data_mem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         r_w;
        logic         in_bus;
        logic         in_mem;
        logic         out_bus;
        logic         out_mem;
        logic         bus_drv;
        logic [W-1:0] bus_val;
        logic         mem_drv;
        logic [W-1:0] mem_val;
        logic [W-1:0] exp_q;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        r_w        = 1'b1;
        in_bus_en  = 1'b0;
        in_mem_en  = 1'b0;
        out_bus_en = 1'b0;
        out_mem_en = 1'b0;
        bus_drv_en = 1'b0;
        mem_drv_en = 1'b0;
        bus_drv    = '0;
        mem_drv    = '0;
    endtask

    // Observe the stored word on data_bus without loading anything.
    task automatic observe(input string name, input logic [W-1:0] exp);
        idle_inputs();
        out_bus_en = 1'b1;
        #1;
        check(name, data_bus, exp);
    endtask

    task automatic load_word(input logic from_mem, input logic [W-1:0] val);
        @(negedge clk);
        idle_inputs();
        if (from_mem) begin
            in_mem_en  = 1'b1;
            mem_drv_en = 1'b1;
            mem_drv    = val;
        end else begin
            r_w        = 1'b0;
            in_bus_en  = 1'b1;
            bus_drv_en = 1'b1;
            bus_drv    = val;
        end
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    initial begin
        n_vec  = 0;
        n_fail = 0;
        // r_w in_bus in_mem out_bus out_mem bus_drv bus_val mem_drv mem_val exp_q
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'hFFFF, 16'hFFFF};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1234, 1'b1, 16'h4321, 16'hFFFF};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'hA5C3, 1'b0, 16'h0000, 16'hA5C3};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h1234, 1'b1, 16'hABCD, 16'hABCD};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h1234, 1'b1, 16'hABCD, 16'h1234};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h5A5A, 1'b1, 16'h0001, 16'h5A5A};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0002, 1'b1, 16'h0F0F, 16'h0F0F};
        // bus self-load guard with a conflicting external driver
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'hFF00, 1'b0, 16'h0000, 16'h0F0F};
        // mem self-load guard (write drive active) with a conflicting external driver
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h3C00, 16'h0F0F};
        // out_mem_en during a read does not drive memory, so the mem load goes ahead
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'hC3C3, 16'hC3C3};
        // tie picks the bus, which is guarded: hold, memory is not taken instead
        vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0001, 1'b1, 16'h7777, 16'hC3C3};
        // tie picks memory while driving the bus: memory load is not guarded
        vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h8001, 16'h8001};
        // loading from the bus while driving memory is allowed
        vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h2468, 1'b0, 16'h0000, 16'h2468};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b1, 16'hFFFF, 16'h2468};

        // Reset with memory at FFFF and all enables low.
        idle_inputs();
        mem_drv_en = 1'b1;
        mem_drv    = 16'hFFFF;
        reset      = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset_mem_undriven", data_mem, 16'hFFFF);
        out_bus_en = 1'b1;
        #1;
        check("reset_q_zero", data_bus, 16'h0000);

        // Table of load vectors.
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            r_w        = vecs[i].r_w;
            in_bus_en  = vecs[i].in_bus;
            in_mem_en  = vecs[i].in_mem;
            out_bus_en = vecs[i].out_bus;
            out_mem_en = vecs[i].out_mem;
            bus_drv_en = vecs[i].bus_drv;
            bus_drv    = vecs[i].bus_val;
            mem_drv_en = vecs[i].mem_drv;
            mem_drv    = vecs[i].mem_val;
            @(posedge clk);
            #1;
            observe($sformatf("vec%0d", i), vecs[i].exp_q);
        end

        // Read: memory FFFF loaded, visible on the bus right after the edge, then held.
        @(negedge clk);
        idle_inputs();
        in_mem_en  = 1'b1;
        mem_drv_en = 1'b1;
        mem_drv    = 16'hFFFF;
        out_bus_en = 1'b1;
        @(posedge clk);
        #1;
        check("read_after_edge", data_bus, 16'hFFFF);
        @(negedge clk);
        in_mem_en = 1'b0;
        mem_drv   = 16'h0000;
        @(posedge clk);
        #1;
        check("read_hold", data_bus, 16'hFFFF);

        // Write: bus A5C3 loaded, then driven to memory only while R_W=0.
        load_word(1'b0, 16'hA5C3);
        r_w        = 1'b0;
        out_mem_en = 1'b1;
        #1;
        check("write_mem_drive", data_mem, 16'hA5C3);
        out_bus_en = 1'b1;
        #1;
        check("bus_drive_during_write", data_bus, 16'hA5C3);
        out_bus_en = 1'b0;
        r_w        = 1'b1;
        mem_drv_en = 1'b1;
        mem_drv    = 16'h0000;
        #1;
        check("read_mem_not_driven", data_mem, 16'h0000);
        bus_drv_en = 1'b1;
        bus_drv    = 16'h0000;
        #1;
        check("bus_not_driven", data_bus, 16'h0000);
        idle_inputs();

        // Output enable takes effect without a clock edge.
        @(negedge clk);
        #2;
        out_bus_en = 1'b1;
        #1;
        check("comb_enable", data_bus, 16'hA5C3);

        // Asynchronous reset between edges with drives active.
        load_word(1'b1, 16'hFFFF);
        @(negedge clk);
        r_w        = 1'b0;
        out_bus_en = 1'b1;
        out_mem_en = 1'b1;
        #1;
        check("pre_reset_bus", data_bus, 16'hFFFF);
        #1;
        reset = 1'b1;
        #1;
        check("async_reset_bus", data_bus, 16'h0000);
        check("async_reset_mem", data_mem, 16'h0000);
        // Loads are ignored while reset is held.
        out_bus_en = 1'b0;
        out_mem_en = 1'b0;
        r_w        = 1'b1;
        in_mem_en  = 1'b1;
        mem_drv_en = 1'b1;
        mem_drv    = 16'h1357;
        @(posedge clk);
        #1;
        idle_inputs();
        out_bus_en = 1'b1;
        #1;
        check("reset_held", data_bus, 16'h0000);
        @(negedge clk);
        reset = 1'b0;

        // Self-load guard with the external bus driver off.
        load_word(1'b1, 16'h00FF);
        @(negedge clk);
        out_bus_en = 1'b1;
        in_bus_en  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("guard_hold%0d", k), data_bus, 16'h00FF);
        end
        idle_inputs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
